// File: rtl/ysyx_22040125_fwd_ctrl.sv
// Forwarding / load-use hazard controller for the EXE-stage operand muxes.
// Keeps a shadow copy of EXE/MEM/WB destination info and registers one-hot selects with ID->EXE.
module ysyx_22040125_fwd_ctrl #(
    parameter int REG_W    = 5,
    parameter int LU_STALL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [1:0]       id_src1_sel,
    input  logic [1:0]       id_src2_sel,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rd_wen,
    input  logic             id_is_load,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             id_ready,
    output logic             exe_valid,
    output logic [2:0]       src1_sel_plus,
    output logic [2:0]       src2_sel_plus
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wen;
        logic             load;
    } stage_t;

    localparam logic [2:0] SEL_NORM = 3'b001;
    localparam logic [2:0] SEL_MEM  = 3'b010;
    localparam logic [2:0] SEL_WB   = 3'b100;

    stage_t     exe_q, mem_q, wb_q;
    stage_t     id_stage;
    logic [2:0] sel1_q, sel2_q;
    logic [2:0] sel1_d, sel2_d;
    logic       load_use;
    logic       advance;
    logic       unused_sink;

    function automatic logic hit(input stage_t s, input logic [REG_W-1:0] rs);
        return s.valid && s.wen && (s.rd == rs) && (rs != '0);
    endfunction

    // Select as seen one cycle later, once the consumer sits in EXE:
    // EXE producer moves to MEM, MEM producer moves to WB, WB producer is covered by the regfile.
    function automatic logic [2:0] fwd_sel(input logic used, input logic [REG_W-1:0] rs,
                                           input stage_t e, input stage_t m);
        if (!used)                     return SEL_NORM;
        if (hit(e, rs) && !e.load)     return SEL_MEM;
        if (hit(m, rs))                return SEL_WB;
        return SEL_NORM;
    endfunction

    always_comb begin
        id_stage.valid = 1'b1;
        id_stage.rd    = id_rd;
        id_stage.wen   = id_rd_wen;
        id_stage.load  = id_is_load;

        load_use = exe_q.load &&
                   ((id_src1_sel[1] && hit(exe_q, id_rs1)) ||
                    (id_src2_sel[1] && hit(exe_q, id_rs2)));
        id_ready = rst_n && !load_use && !mem_stall;
        advance  = id_valid && id_ready && !flush;

        sel1_d = fwd_sel(id_src1_sel[1], id_rs1, exe_q, mem_q);
        sel2_d = fwd_sel(id_src2_sel[1], id_rs2, exe_q, mem_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exe_q  <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            sel1_q <= SEL_NORM;
            sel2_q <= SEL_NORM;
        end else if (mem_stall) begin
            // frozen pipeline, but a redirect still kills the EXE slot
            if (flush) begin
                exe_q  <= '0;
                sel1_q <= SEL_NORM;
                sel2_q <= SEL_NORM;
            end
        end else begin
            wb_q   <= mem_q;
            mem_q  <= exe_q;
            exe_q  <= advance ? id_stage : '0;
            sel1_q <= advance ? sel1_d : SEL_NORM;
            sel2_q <= advance ? sel2_d : SEL_NORM;
        end
    end

    assign exe_valid     = exe_q.valid;
    assign src1_sel_plus = sel1_q;
    assign src2_sel_plus = sel2_q;

    // Operand pc/imm bits, WB shadow and MEM load flag carry no forwarding decision.
    assign unused_sink = ^{id_src1_sel[0], id_src2_sel[0], wb_q, mem_q.load, (LU_STALL == 1)};

endmodule
